// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte stream in, verified frame out, for the UART receive path.
// slave = frame controller view, master = host/receiver side.
interface uart_rx_frame_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              frame_valid;
  logic              frame_ack;
  logic [7:0]        frame_cmd;
  logic [7:0]        frame_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              busy;
  logic              err_chk;
  logic              err_len;
  logic              err_overrun;
  logic              err_timeout;

  modport slave (
    input  rx_data, rx_valid, frame_ack, rd_addr,
    output frame_valid, frame_cmd, frame_len, rd_data,
    output busy, err_chk, err_len, err_overrun, err_timeout
  );

  modport master (
    output rx_data, rx_valid, frame_ack, rd_addr,
    input  frame_valid, frame_cmd, frame_len, rd_data,
    input  busy, err_chk, err_len, err_overrun, err_timeout
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller: SOF, LEN, CMD, payload, CHK -> held frame.
// Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN     = 16,
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] SOF         = 8'hAA,
  parameter int         TIMEOUT_CYC = 43400
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_rx_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_CMD,
    S_PAY,
    S_CHK,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        fcmd_q, fcmd_d;
  logic [7:0]        flen_q, flen_d;
  logic              busy_q;
  logic              err_chk_q, err_chk_d;
  logic              err_len_q, err_len_d;
  logic              err_ovr_q, err_ovr_d;
  logic              err_tmo_q, err_tmo_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        mem_q [MAX_LEN];
  logic              wr_en;
  logic              timeout_hit;
  logic              in_frame;

  assign in_frame = (state_q == S_LEN) || (state_q == S_CMD) ||
                    (state_q == S_PAY) || (state_q == S_CHK);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYC);

  logic [GAP_W-1:0] gap_q, gap_d;

  assign timeout_hit = in_frame && !bus.rx_valid &&
                       (gap_q == GAP_W'(TIMEOUT_CYC - 1));

  // Gap counter: runs between bytes of a partial frame only
  always_comb begin
    gap_d = '0;
    if (in_frame && !bus.rx_valid && !timeout_hit)
      gap_d = gap_q + GAP_W'(1);
  end

  // Gap counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, datapath and error pulse decode
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cmd_d     = cmd_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    fcmd_d    = fcmd_q;
    flen_d    = flen_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_ovr_d = 1'b0;
    err_tmo_d = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == SOF)
          state_d = S_LEN;
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          if (int'(bus.rx_data) > MAX_LEN) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = bus.rx_data;
            sum_d   = bus.rx_data;
            idx_d   = '0;
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (bus.rx_valid) begin
          cmd_d   = bus.rx_data;
          sum_d   = sum_q + bus.rx_data;
          state_d = (len_q != 8'd0) ? S_PAY : S_CHK;
        end
      end
      S_PAY: begin
        if (bus.rx_valid) begin
          wr_en = 1'b1;
          sum_d = sum_q + bus.rx_data;
          if (8'(idx_q) == len_q - 8'd1) begin
            idx_d   = '0;
            state_d = S_CHK;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            fcmd_d  = cmd_q;
            flen_d  = len_q;
            state_d = S_DONE;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DONE: begin
        // An ack releases the frame; a byte in the same cycle
        // is then treated as the first byte after release.
        if (bus.frame_ack) begin
          if (bus.rx_valid && bus.rx_data == SOF) state_d = S_LEN;
          else                                    state_d = S_IDLE;
        end else if (bus.rx_valid) begin
          err_ovr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      err_tmo_d = 1'b1;
      state_d   = S_IDLE;
    end
  end

  // Registered buffer read port, usable in any state
  always_comb begin
    rd_data_d = '0;
    if (int'(bus.rd_addr) < MAX_LEN)
      rd_data_d = mem_q[bus.rd_addr];
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cmd_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      fcmd_q    <= '0;
      flen_q    <= '0;
      busy_q    <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_ovr_q <= 1'b0;
      err_tmo_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cmd_q     <= cmd_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      fcmd_q    <= fcmd_d;
      flen_q    <= flen_d;
      busy_q    <= (state_d != S_IDLE);
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_ovr_q <= err_ovr_d;
      err_tmo_q <= err_tmo_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Payload buffer; stale bytes beyond frame_len are left in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx_q] <= bus.rx_data;
    end
  end

  assign bus.frame_valid = (state_q == S_DONE);
  assign bus.frame_cmd   = fcmd_q;
  assign bus.frame_len   = flen_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_overrun = err_ovr_q;
  assign bus.err_timeout = err_tmo_q;

endmodule
